// File: rtl/int_arbiter_pkg.sv
// Shared definitions for the interrupt arbiter: state encoding, default cause
// base and the architectural cause codes of the standard interrupt sources.
package int_defs;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_REQ     = 2'd1,
        ST_SERVICE = 2'd2
    } int_state_e;

    localparam logic [3:0] CAUSE_BASE_DEF = 4'h8;

    localparam logic [3:0] ECAUSE_EXT   = 4'h8;
    localparam logic [3:0] ECAUSE_PS2   = 4'h9;
    localparam logic [3:0] ECAUSE_TIMER = 4'hA;
    localparam logic [3:0] ECAUSE_UART  = 4'hB;

endpackage

// File: rtl/int_prio_enc.sv
// Lowest-set-bit priority encoder: bit 0 is the highest priority request.
module int_prio_enc #(
    parameter int N  = 4,
    parameter int IW = 2
) (
    input  logic [N-1:0]  req,
    output logic [IW-1:0] idx,
    output logic          valid
);

    // Scanning downward lets the lowest set bit be the last (winning) write.
    always_comb begin
        idx   = '0;
        valid = 1'b0;
        for (int i = N - 1; i >= 0; i--) begin
            if (req[i]) begin
                idx   = IW'(i);
                valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/int_arbiter.sv
// Interrupt arbiter: latches source edges as pending, grants one by fixed
// priority with EPC correction, and holds off further grants until ERET.
module int_arbiter
    import int_defs::*;
#(
    parameter int         NUM_SRC    = 4,
    parameter logic [3:0] CAUSE_BASE = CAUSE_BASE_DEF
) (
    input  logic               inti_clk,
    input  logic               inti_rst,
    input  logic [NUM_SRC-1:0] inti_src,
    input  logic [NUM_SRC-1:0] inti_mask,
    input  logic               inti_global_en,
    input  logic [15:0]        inti_pc,
    input  logic               inti_in_bds,
    input  logic               inti_is_branch,
    input  logic               inti_ack,
    input  logic               inti_eret,
    input  logic               inti_overrun_clr,
    output logic               into_req,
    output logic [3:0]         into_cause,
    output logic [15:0]        into_epc,
    output logic               into_handling,
    output logic [NUM_SRC-1:0] into_pending,
    output logic [NUM_SRC-1:0] into_overrun
);

    localparam int IDX_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

    int_state_e         state_q, state_d;
    logic [NUM_SRC-1:0] pending_q, pending_d;
    logic [NUM_SRC-1:0] overrun_q, overrun_d;
    logic [NUM_SRC-1:0] hist_q, hist_d;
    logic               armed_q, armed_d;
    logic               cool_q, cool_d;
    logic [3:0]         cause_q, cause_d;
    logic [15:0]        epc_q, epc_d;

    logic [NUM_SRC-1:0] src_edge;
    logic [NUM_SRC-1:0] elig;
    logic [NUM_SRC-1:0] grant_vec;
    logic [IDX_W-1:0]   enc_idx;
    logic               enc_valid;
    logic               grant;

    assign elig = pending_q & inti_mask;

    int_prio_enc #(
        .N  (NUM_SRC),
        .IW (IDX_W)
    ) u_prio_enc (
        .req   (elig),
        .idx   (enc_idx),
        .valid (enc_valid)
    );

    // armed_q masks the first cycle after reset so a level held through reset
    // is not mistaken for a fresh edge; cool_q forces one IDLE cycle after ERET.
    always_comb begin
        src_edge  = armed_q ? (inti_src & ~hist_q) : '0;
        grant     = (state_q == ST_IDLE) && !cool_q && inti_global_en && enc_valid;
        grant_vec = grant ? (NUM_SRC'(1) << enc_idx) : '0;

        state_d = state_q;
        case (state_q)
            ST_IDLE:    if (grant)     state_d = ST_REQ;
            ST_REQ:     if (inti_ack)  state_d = ST_SERVICE;
            ST_SERVICE: if (inti_eret) state_d = ST_IDLE;
            default:                   state_d = ST_IDLE;
        endcase

        pending_d = (pending_q & ~grant_vec) | src_edge;
        overrun_d = (inti_overrun_clr ? '0 : overrun_q) | (src_edge & pending_q & ~grant_vec);
        hist_d    = inti_src;
        armed_d   = 1'b1;
        cool_d    = (state_q == ST_SERVICE) && inti_eret;

        cause_d = cause_q;
        epc_d   = epc_q;
        if (grant) begin
            cause_d = CAUSE_BASE + 4'(enc_idx);
            if (inti_in_bds)
                epc_d = inti_pc - 16'd1;
            else if (inti_is_branch)
                epc_d = inti_pc;
            else
                epc_d = inti_pc + 16'd1;
        end
    end

    always_ff @(posedge inti_clk) begin
        if (inti_rst) begin
            state_q   <= ST_IDLE;
            pending_q <= '0;
            overrun_q <= '0;
            hist_q    <= '0;
            armed_q   <= 1'b0;
            cool_q    <= 1'b0;
            cause_q   <= '0;
            epc_q     <= '0;
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
            overrun_q <= overrun_d;
            hist_q    <= hist_d;
            armed_q   <= armed_d;
            cool_q    <= cool_d;
            cause_q   <= cause_d;
            epc_q     <= epc_d;
        end
    end

    assign into_req      = (state_q == ST_REQ);
    assign into_handling = (state_q == ST_REQ) || (state_q == ST_SERVICE);
    assign into_cause    = cause_q;
    assign into_epc      = epc_q;
    assign into_pending  = pending_q;
    assign into_overrun  = overrun_q;

endmodule

// File: tb/tb_int_arbiter.sv
// Self-checking bench for int_arbiter: directed sequences, an EPC vector table
// and randomized traffic, all compared against a behavioural model.
module tb_int_arbiter;

    logic        inti_clk;
    logic        inti_rst;
    logic [3:0]  inti_src;
    logic [3:0]  inti_mask;
    logic        inti_global_en;
    logic [15:0] inti_pc;
    logic        inti_in_bds;
    logic        inti_is_branch;
    logic        inti_ack;
    logic        inti_eret;
    logic        inti_overrun_clr;
    logic        into_req;
    logic [3:0]  into_cause;
    logic [15:0] into_epc;
    logic        into_handling;
    logic [3:0]  into_pending;
    logic [3:0]  into_overrun;

    int_arbiter #(
        .NUM_SRC    (4),
        .CAUSE_BASE (4'h8)
    ) dut (
        .inti_clk         (inti_clk),
        .inti_rst         (inti_rst),
        .inti_src         (inti_src),
        .inti_mask        (inti_mask),
        .inti_global_en   (inti_global_en),
        .inti_pc          (inti_pc),
        .inti_in_bds      (inti_in_bds),
        .inti_is_branch   (inti_is_branch),
        .inti_ack         (inti_ack),
        .inti_eret        (inti_eret),
        .inti_overrun_clr (inti_overrun_clr),
        .into_req         (into_req),
        .into_cause       (into_cause),
        .into_epc         (into_epc),
        .into_handling    (into_handling),
        .into_pending     (into_pending),
        .into_overrun     (into_overrun)
    );

    initial inti_clk = 1'b0;
    always #5 inti_clk = ~inti_clk;

    int tests = 0;
    int fails = 0;

    // Behavioural model: phase 0 = idle, 1 = waiting for ack, 2 = in handler.
    logic [3:0]  m_pending, m_overrun, m_prev;
    int          m_phase;
    bit          m_cool;
    logic [3:0]  m_cause;
    logic [15:0] m_epc;

    typedef struct {
        logic [15:0] pc;
        logic        bds;
        logic        br;
        logic [15:0] epc;
    } epc_vec_t;

    epc_vec_t epc_tab[5];

    task automatic modelStep();
        logic [3:0] edges;
        logic [3:0] old_pend;
        int ph, g, p;
        if (inti_rst) begin
            m_pending = '0; m_overrun = '0; m_prev = 4'hF;
            m_phase = 0; m_cool = 0; m_cause = '0; m_epc = '0;
            return;
        end
        ph       = m_phase;
        edges    = inti_src & ~m_prev;
        m_prev   = inti_src;
        old_pend = m_pending;
        g        = -1;
        if (ph == 0 && !m_cool && inti_global_en)
            for (int i = 0; i < 4; i++)
                if (g < 0 && m_pending[i] && inti_mask[i]) g = i;
        if (g >= 0) begin
            m_pending[g] = 1'b0;
            m_cause = 4'((8 + g) % 16);
            p = int'(inti_pc);
            if (inti_in_bds)         p = (p + 65535) % 65536;
            else if (!inti_is_branch) p = (p + 1) % 65536;
            m_epc = 16'(p);
        end
        if (inti_overrun_clr) m_overrun = '0;
        for (int i = 0; i < 4; i++)
            if (edges[i] && old_pend[i] && g != i) m_overrun[i] = 1'b1;
        m_pending = m_pending | edges;
        m_cool = (ph == 2) && inti_eret;
        if (ph == 1 && inti_ack)       m_phase = 2;
        else if (ph == 2 && inti_eret) m_phase = 0;
        else if (g >= 0)               m_phase = 1;
    endtask

    task automatic expectVal(input string name, input logic [15:0] act, input logic [15:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic checkOutput();
        expectVal("model req",      16'(into_req),      16'(m_phase == 1));
        expectVal("model handling", 16'(into_handling), 16'(m_phase != 0));
        expectVal("model cause",    16'(into_cause),    16'(m_cause));
        expectVal("model epc",      into_epc,           m_epc);
        expectVal("model pending",  16'(into_pending),  16'(m_pending));
        expectVal("model overrun",  16'(into_overrun),  16'(m_overrun));
    endtask

    task automatic tick();
        modelStep();
        @(posedge inti_clk);
        #1;
        checkOutput();
    endtask

    task automatic applyStimulus(input logic [3:0] src, input logic ack, input logic eret,
                                 input logic rst, input logic ovclr);
        inti_src         = src;
        inti_ack         = ack;
        inti_eret        = eret;
        inti_rst         = rst;
        inti_overrun_clr = ovclr;
        tick();
    endtask

    task automatic checkReset(input string name);
        expectVal({name, " req"},      16'(into_req),      16'h0);
        expectVal({name, " handling"}, 16'(into_handling), 16'h0);
        expectVal({name, " cause"},    16'(into_cause),    16'h0);
        expectVal({name, " epc"},      into_epc,           16'h0);
        expectVal({name, " pending"},  16'(into_pending),  16'h0);
        expectVal({name, " overrun"},  16'(into_overrun),  16'h0);
    endtask

    // Pulse one source, wait for the grant and report; leaves the arbiter in REQ.
    task automatic pulseAndGrant(input logic [3:0] src);
        applyStimulus(src, 0, 0, 0, 0);
        applyStimulus(4'h0, 0, 0, 0, 0);
    endtask

    task automatic finishHandler();
        applyStimulus(4'h0, 1, 0, 0, 0);
        applyStimulus(4'h0, 0, 1, 0, 0);
        applyStimulus(4'h0, 0, 0, 0, 0);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL timeout: simulation did not finish, got running expected done");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        epc_tab[0] = '{pc: 16'h0000, bds: 1'b1, br: 1'b0, epc: 16'hFFFF};
        epc_tab[1] = '{pc: 16'h0040, bds: 1'b0, br: 1'b1, epc: 16'h0040};
        epc_tab[2] = '{pc: 16'h0040, bds: 1'b1, br: 1'b1, epc: 16'h003F};
        epc_tab[3] = '{pc: 16'hFFFF, bds: 1'b0, br: 1'b0, epc: 16'h0000};
        epc_tab[4] = '{pc: 16'h1234, bds: 1'b0, br: 1'b0, epc: 16'h1235};

        inti_mask = 4'hF; inti_global_en = 1'b1; inti_pc = 16'h0100;
        inti_in_bds = 1'b0; inti_is_branch = 1'b0;
        applyStimulus(4'h0, 0, 0, 1, 0);
        applyStimulus(4'h0, 0, 0, 1, 0);
        checkReset("reset");
        applyStimulus(4'h0, 0, 0, 0, 0);

        // Single source, 2-cycle latency, ack then eret.
        applyStimulus(4'b0010, 0, 0, 0, 0);
        expectVal("t1 pending", 16'(into_pending), 16'h2);
        expectVal("t1 req early", 16'(into_req), 16'h0);
        applyStimulus(4'h0, 0, 0, 0, 0);
        expectVal("t1 req", 16'(into_req), 16'h1);
        expectVal("t1 cause", 16'(into_cause), 16'h9);
        expectVal("t1 epc", into_epc, 16'h0101);
        applyStimulus(4'h0, 1, 0, 0, 0);
        expectVal("t1 req after ack", 16'(into_req), 16'h0);
        expectVal("t1 handling", 16'(into_handling), 16'h1);
        applyStimulus(4'h0, 0, 1, 0, 0);
        applyStimulus(4'h0, 0, 0, 0, 0);

        // Two simultaneous sources, priority and post-ERET gap.
        pulseAndGrant(4'b0101);
        expectVal("t2 cause first", 16'(into_cause), 16'h8);
        expectVal("t2 pending", 16'(into_pending), 16'h4);
        applyStimulus(4'h0, 1, 0, 0, 0);
        applyStimulus(4'h0, 0, 0, 0, 0);
        applyStimulus(4'h0, 0, 1, 0, 0);
        expectVal("t2 req eret+1", 16'(into_req), 16'h0);
        applyStimulus(4'h0, 0, 0, 0, 0);
        expectVal("t2 req eret+1 gap", 16'(into_req), 16'h0);
        applyStimulus(4'h0, 0, 0, 0, 0);
        expectVal("t2 req eret+2", 16'(into_req), 16'h1);
        expectVal("t2 cause second", 16'(into_cause), 16'hA);
        finishHandler();

        // EPC correction table.
        for (int i = 0; i < 5; i++) begin
            inti_pc = epc_tab[i].pc; inti_in_bds = epc_tab[i].bds; inti_is_branch = epc_tab[i].br;
            pulseAndGrant(4'b0001);
            expectVal($sformatf("epc vec %0d", i), into_epc, epc_tab[i].epc);
            expectVal($sformatf("epc req %0d", i), 16'(into_req), 16'h1);
            finishHandler();
        end
        inti_pc = 16'h0100; inti_in_bds = 1'b0; inti_is_branch = 1'b0;

        // Masking by source mask, then by global enable.
        inti_mask = 4'b0111;
        pulseAndGrant(4'b1000);
        applyStimulus(4'h0, 0, 0, 0, 0);
        expectVal("mask req", 16'(into_req), 16'h0);
        expectVal("mask pending", 16'(into_pending), 16'h8);
        inti_mask = 4'hF;
        applyStimulus(4'h0, 0, 0, 0, 0);
        expectVal("unmask cause", 16'(into_cause), 16'hB);
        expectVal("unmask req", 16'(into_req), 16'h1);
        finishHandler();
        inti_global_en = 1'b0;
        pulseAndGrant(4'b1000);
        applyStimulus(4'h0, 0, 0, 0, 0);
        expectVal("gen req", 16'(into_req), 16'h0);
        inti_global_en = 1'b1;
        applyStimulus(4'h0, 0, 0, 0, 0);
        expectVal("gen on req", 16'(into_req), 16'h1);
        expectVal("gen on cause", 16'(into_cause), 16'hB);
        finishHandler();

        // Overrun while in service, then clear.
        pulseAndGrant(4'b0001);
        applyStimulus(4'h0, 1, 0, 0, 0);
        pulseAndGrant(4'b0010);
        pulseAndGrant(4'b0010);
        expectVal("ovr pending", 16'(into_pending), 16'h2);
        expectVal("ovr overrun", 16'(into_overrun), 16'h2);
        applyStimulus(4'h0, 0, 0, 0, 1);
        expectVal("ovr cleared", 16'(into_overrun), 16'h0);
        expectVal("ovr pending kept", 16'(into_pending), 16'h2);
        applyStimulus(4'h0, 0, 1, 0, 0);
        applyStimulus(4'h0, 0, 0, 0, 0);
        applyStimulus(4'h0, 0, 0, 0, 0);
        finishHandler();

        // Reset in REQ and in SERVICE; level held across reset.
        pulseAndGrant(4'b0001);
        applyStimulus(4'h0, 0, 0, 1, 0);
        checkReset("rst in req");
        applyStimulus(4'h0, 0, 0, 0, 0);
        pulseAndGrant(4'b0001);
        applyStimulus(4'h0, 1, 0, 0, 0);
        applyStimulus(4'h0, 0, 0, 1, 0);
        checkReset("rst in service");
        applyStimulus(4'b0100, 0, 0, 1, 0);
        for (int i = 0; i < 3; i++) applyStimulus(4'b0100, 0, 0, 0, 0);
        expectVal("held src req", 16'(into_req), 16'h0);
        expectVal("held src pending", 16'(into_pending), 16'h0);
        applyStimulus(4'h0, 0, 0, 0, 0);

        // Randomized traffic against the model.
        for (int c = 0; c < 3000; c++) begin
            inti_mask      = 4'($urandom);
            inti_global_en = ($urandom_range(0, 7) != 0);
            inti_pc        = 16'($urandom);
            inti_in_bds    = ($urandom_range(0, 3) == 0);
            inti_is_branch = ($urandom_range(0, 2) == 0);
            applyStimulus(4'($urandom & $urandom), ($urandom_range(0, 2) == 0),
                          ($urandom_range(0, 3) == 0), ($urandom_range(0, 99) == 0),
                          ($urandom_range(0, 15) == 0));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/int_arbiter.md
Name: int_arbiter

Overview:
- Collects interrupt requests from NUM_SRC peripheral sources (external pin, PS/2, timer, UART, ...), latches them as pending, and selects one by fixed priority.
- Captures the return EPC with branch/delay-slot correction and hands one interrupt at a time to the pipeline scheduler through a req/ack handshake.
- Blocks further grants until the handler executes ERET.
- Sits between the peripheral interrupt lines and the scheduler's PC-redirect logic.

Parameters:
- NUM_SRC, 4: number of interrupt sources. Index 0 is the highest priority.
- CAUSE_BASE, 4'h8: into_cause = CAUSE_BASE + granted index, 4-bit, modulo 16.

Ports:
- inti_clk  in  1  clock; all state updates on the rising edge.
- inti_rst  in  1  synchronous, active-high reset.
- inti_src  in  NUM_SRC  interrupt request levels; a rising edge raises a request.
- inti_mask  in  NUM_SRC  1 = source enabled for grant.
- inti_global_en  in  1  global interrupt enable.
- inti_pc  in  16  PC of the instruction currently in the interrupted stage.
- inti_in_bds  in  1  that instruction is in a branch delay slot.
- inti_is_branch  in  1  that instruction is a branch.
- inti_ack  in  1  scheduler has redirected the PC to the vector.
- inti_eret  in  1  handler is returning (single-cycle).
- inti_overrun_clr  in  1  clears into_overrun.
- into_req  out  1  interrupt request to the scheduler.
- into_cause  out  4  cause of the granted interrupt.
- into_epc  out  16  return address to save.
- into_handling  out  1  high in REQ and SERVICE.
- into_pending  out  NUM_SRC  pending request bits.
- into_overrun  out  NUM_SRC  sticky: an edge arrived while that bit was already pending.

Behaviour:
- Reset (inti_rst=1 at an edge), including mid-operation in any state:
  - state <= IDLE.
  - pending, overrun, edge-detect history <= 0.
  - into_req=0, into_cause=0, into_epc=0, into_handling=0.
  - An inti_src level still high after reset does not count as an edge.
- Edge detection:
  - edge[i] = inti_src[i] & ~src_d[i]; src_d is registered every cycle.
  - edge[i] sets pending[i] at that clock edge.
  - If pending[i] is already 1 when edge[i] occurs, overrun[i] <= 1.
- Eligibility:
  - elig = pending & inti_mask, considered only when inti_global_en=1 and state=IDLE.
  - Masked or disabled requests stay pending; they are neither lost nor granted.
- Grant (IDLE with elig != 0), at the next edge:
  - state <= REQ.
  - pending[g] <= 0, where g = lowest set index of elig.
  - into_cause <= CAUSE_BASE + g.
  - into_epc <= inti_pc-1 if inti_in_bds; else inti_pc if inti_is_branch; else inti_pc+1. Arithmetic is 16-bit, wraps modulo 2^16, and in_bds takes precedence.
- Simultaneous set and clear on the same bit: a new edge on g in the grant cycle leaves pending[g]=1 (set wins) and does not set overrun.
- Latency: inti_src rises before edge E1, so pending is set at E1. into_req is high after E2 if the source is eligible. Total latency is 2 cycles.
- REQ state:
  - into_req=1; into_cause and into_epc are held stable.
  - inti_ack=1 at an edge: state <= SERVICE, into_req <= 0.
  - inti_eret in REQ is ignored.
  - Changes to inti_mask or inti_global_en do not withdraw a request already issued.
- SERVICE state:
  - into_req=0, into_handling=1; no grants.
  - inti_eret=1: state <= IDLE.
  - inti_ack in SERVICE is ignored.
- After ERET there is at least one IDLE cycle before the next grant: into_req rises no earlier than 2 edges after the ERET edge.
- inti_overrun_clr clears all overrun bits. If an overrun set happens in the same cycle, the set wins.
- States are IDLE, REQ and SERVICE; the remaining encoding is illegal and recovers to IDLE.

Decomposition:
- Shared package int_defs:
  - state encoding: ST_IDLE=2'd0, ST_REQ=2'd1, ST_SERVICE=2'd2.
  - CAUSE_BASE default.
  - ECAUSE_* constants.
- One sub-module, int_prio_enc: combinational NUM_SRC-to-index/valid lowest-set-bit encoder, instantiated once.

Test Plan:
- Reset, then pulse inti_src[1] with mask=4'hF, global_en=1, pc=16'h0100, no branch -> into_req high 2 cycles after the pulse edge, cause=4'h9, epc=16'h0101; ack -> into_req drops the next cycle, into_handling stays 1.
- Pulse src[2] and src[0] in the same cycle -> cause 4'h8 granted first, pending=4'b0100. After ack and eret, cause 4'hA is granted, with into_req rising exactly 2 edges after the eret edge.
- Delay-slot correction:
  - in_bds=1, pc=16'h0000 -> epc=16'hFFFF (wrap).
  - is_branch=1, pc=16'h0040 -> epc=16'h0040.
  - both set, pc=16'h0040 -> epc=16'h003F.
- Masking: mask[3]=0, pulse src[3] -> no req, pending[3]=1. Set mask[3]=1 -> req with cause 4'hB. Same check with global_en=0, then 1.
- Overrun: pulse src[1] twice while in SERVICE -> pending[1]=1, overrun[1]=1. Overrun_clr -> overrun=0; pending remains.
- Reset asserted in REQ and again in SERVICE -> next cycle all outputs 0, state IDLE. A src held high across reset does not generate a request.
